// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_D         = 10;
  localparam int unsigned PC_LUT_AW    = 4;
  localparam int unsigned PC_STK_DEPTH = 4;

  localparam logic [PC_D-1:0] PC_RESET = '0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  typedef enum logic [2:0] {
    NPC_HOLD,
    NPC_INC,
    NPC_ABS,
    NPC_REL,
    NPC_POP
  } npc_sel_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/LUT/status bundle between the fetch decoder (master) and the PC sequencer (slave).
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int unsigned D      = PC_D,
  parameter int unsigned LUT_AW = PC_LUT_AW
);

  logic              start;
  logic              stall;
  logic              halt_req;
  logic              branch_en;
  logic              rel_en;
  logic              call_en;
  logic              ret_en;
  logic [LUT_AW-1:0] lut_idx;
  logic [LUT_AW-1:0] lut_addr;
  logic [D-1:0]      lut_target;
  logic [D-1:0]      pc;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, stall, halt_req, branch_en, rel_en, call_en, ret_en,
    output lut_idx, lut_target,
    input  lut_addr, pc, busy, done, err
  );

  modport slave (
    input  start, stall, halt_req, branch_en, rel_en, call_en, ret_en,
    input  lut_idx, lut_target,
    output lut_addr, pc, busy, done, err
  );

endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO; a push when full or a pop when empty leaves the stack unchanged.
module pc_ret_stack #(
  parameter int unsigned D     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [D-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt_q;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign top   = empty ? '0 : mem[PW'(cnt_q - CW'(1))];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      mem[PW'(cnt_q)] <= push_data;
      cnt_q           <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: IDLE/RUN/HALTED sequencing with increment, jumps, call and return.
// Optional return stack enabled by defining PC_RET_STACK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned D = PC_D
) (
  input logic            clk,
  input logic            reset_n,
  pc_sequencer_if.slave  bus
);

  state_t       state_q, state_d;
  npc_sel_t     npc_sel;
  logic         pc_clr;
  logic [D-1:0] pc_q, pc_d;
  logic         busy_q, done_q;

`ifdef PC_RET_STACK_EN
  logic         stk_push, stk_pop, stk_full, stk_empty;
  logic [D-1:0] stk_top;
  logic         err_set, err_q;

  pc_ret_stack #(
    .D     (D),
    .DEPTH (PC_STK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_q + D'(1)),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.lut_addr = bus.lut_idx;
  assign bus.pc       = pc_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  // Phase sequencing and per-cycle next-PC decision
  always_comb begin
    state_d = state_q;
    npc_sel = NPC_HOLD;
    pc_clr  = 1'b0;
`ifdef PC_RET_STACK_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    err_set  = 1'b0;
`endif
    unique case (state_q)
      IDLE, HALTED: begin
        if (bus.start) begin
          state_d = RUN;
          pc_clr  = 1'b1;
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d = HALTED;
        end else if (bus.stall) begin
          npc_sel = NPC_HOLD;
`ifdef PC_RET_STACK_EN
        end else if (bus.ret_en) begin
          // A return with nothing to return to just falls through
          if (stk_empty) begin
            npc_sel = NPC_INC;
            err_set = 1'b1;
          end else begin
            npc_sel = NPC_POP;
            stk_pop = 1'b1;
          end
        end else if (bus.call_en) begin
          npc_sel = NPC_ABS;
          if (stk_full) err_set  = 1'b1;
          else          stk_push = 1'b1;
`else
        end else if (bus.call_en) begin
          npc_sel = NPC_ABS;
`endif
        end else if (bus.branch_en) begin
          npc_sel = bus.rel_en ? NPC_REL : NPC_ABS;
        end else begin
          npc_sel = NPC_INC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-PC mux; all arithmetic wraps modulo 2**D
  always_comb begin
    pc_d = pc_q;
    if (pc_clr) begin
      pc_d = D'(PC_RESET);
    end else begin
      case (npc_sel)
        NPC_INC: pc_d = pc_q + D'(1);
        NPC_ABS: pc_d = bus.lut_target;
        NPC_REL: pc_d = pc_q + bus.lut_target;
`ifdef PC_RET_STACK_EN
        NPC_POP: pc_d = stk_top;
`endif
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= D'(PC_RESET);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == HALTED);
    end
  end

`ifdef PC_RET_STACK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_q | err_set;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: reference model plus directed literal checks.
module tb_pc_sequencer;

  localparam int unsigned D    = 10;
  localparam int          MODV = 1 << D;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pc_sequencer_if #(.D(D), .LUT_AW(4)) bus ();

  pc_sequencer #(.D(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0=idle 1=run 2=halted, PC as an integer modulo 2**D
  int m_state = 0;
  int m_pc    = 0;
  int m_err   = 0;
  int stk[$];

  always @(posedge clk) begin
    if (!reset_n) begin
      m_state = 0;
      m_pc    = 0;
      m_err   = 0;
      stk.delete();
    end else if (m_state == 1) begin
      if (bus.halt_req) m_state = 2;
      else if (bus.stall) m_pc = m_pc;
`ifdef PC_RET_STACK_EN
      else if (bus.ret_en) begin
        if (stk.size() == 0) begin
          m_pc  = (m_pc + 1) % MODV;
          m_err = 1;
        end else begin
          m_pc = stk.pop_back();
        end
      end else if (bus.call_en) begin
        if (stk.size() == 4) m_err = 1;
        else stk.push_back((m_pc + 1) % MODV);
        m_pc = int'(bus.lut_target);
      end
`else
      else if (bus.call_en) m_pc = int'(bus.lut_target);
`endif
      else if (bus.branch_en && bus.rel_en) m_pc = (m_pc + int'(bus.lut_target)) % MODV;
      else if (bus.branch_en) m_pc = int'(bus.lut_target);
      else m_pc = (m_pc + 1) % MODV;
    end else if (bus.start) begin
      m_state = 1;
      m_pc    = 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc",       int'(bus.pc),       m_pc);
      check("busy",     int'(bus.busy),     int'(m_state == 1));
      check("done",     int'(bus.done),     int'(m_state == 2));
      check("err",      int'(bus.err),      m_err);
      check("lut_addr", int'(bus.lut_addr), int'(bus.lut_idx));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.lut_idx = 4'($urandom_range(0, 15));
  endtask

  task automatic clr_ctl();
    bus.start = 0; bus.stall = 0; bus.halt_req = 0; bus.branch_en = 0;
    bus.rel_en = 0; bus.call_en = 0; bus.ret_en = 0;
  endtask

  task automatic jump_abs(input int tgt);
    clr_ctl();
    bus.branch_en = 1; bus.lut_target = 10'(tgt);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_pc;
    int exp_err;
    reset_n = 0;
    clr_ctl();
    bus.lut_idx = '0;
    bus.lut_target = '0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_pc", int'(bus.pc), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    reset_n = 1;

    // Sequential run from start
    bus.start = 1; tick(); clr_ctl();
    check("t1_pc0", int'(bus.pc), 0);
    check("t1_busy", int'(bus.busy), 1);
    repeat (4) tick();
    check("t1_pc4", int'(bus.pc), 4);

    // Absolute and relative branches
    jump_abs(11);
    check("t2_abs11", int'(bus.pc), 11);
    jump_abs(4);
    bus.rel_en = 1; bus.lut_target = 10'h3FF; tick();
    check("t3_rel_m1", int'(bus.pc), 3);
    jump_abs(4);
    bus.rel_en = 1; bus.lut_target = 10'h3FB; tick();
    check("t3_rel_m5", int'(bus.pc), 1023);

    // Wrap and stall
    jump_abs(1023);
    clr_ctl(); tick();
    check("t4_wrap", int'(bus.pc), 0);
    bus.stall = 1; bus.branch_en = 1; repeat (3) tick();
    check("t4_stall", int'(bus.pc), 0);

    // Halt holds the PC and ignores controls; start restarts at 0
    jump_abs(17);
    clr_ctl(); bus.halt_req = 1; tick();
    check("t5_done", int'(bus.done), 1);
    clr_ctl(); bus.branch_en = 1; bus.call_en = 1; bus.lut_target = 10'd5;
    repeat (10) tick();
    check("t5_hold", int'(bus.pc), 17);
    check("t5_done_hold", int'(bus.done), 1);
    clr_ctl(); bus.start = 1; tick(); clr_ctl();
    check("t5_restart_pc", int'(bus.pc), 0);
    check("t5_restart_done", int'(bus.done), 0);
    repeat (2) tick();
    bus.start = 1; tick(); clr_ctl();
    check("t5_start_ignored", int'(bus.pc), 3);
    reset_n = 0; tick(); reset_n = 1;
    check("t5_rst_pc", int'(bus.pc), 0);
    check("t5_rst_busy", int'(bus.busy), 0);
    bus.branch_en = 1; bus.lut_target = 10'd9; tick(); clr_ctl();
    check("t5_idle_ignores", int'(bus.pc), 0);

    // Call / return
    bus.start = 1; tick(); clr_ctl();
    jump_abs(2);
    clr_ctl(); bus.call_en = 1; bus.lut_target = 10'd17; tick();
    check("t6_call", int'(bus.pc), 17);
    clr_ctl(); bus.ret_en = 1; tick();
`ifdef PC_RET_STACK_EN
    exp_pc = 3; exp_err = 1;
`else
    exp_pc = 18; exp_err = 0;
`endif
    check("t6_ret", int'(bus.pc), exp_pc);
    for (int i = 0; i < 5; i++) begin
      clr_ctl(); bus.call_en = 1; bus.lut_target = 10'(100 + i); tick();
    end
    check("t6_overflow_err", int'(bus.err), exp_err);
    clr_ctl(); bus.ret_en = 1; repeat (5) tick();
`ifdef PC_RET_STACK_EN
    exp_pc = 5;
`else
    exp_pc = 109;
`endif
    check("t6_underflow_pc", int'(bus.pc), exp_pc);
    clr_ctl(); bus.call_en = 1; bus.lut_target = 10'd50; tick();
    bus.ret_en = 1; bus.lut_target = 10'd70; tick(); clr_ctl();
`ifdef PC_RET_STACK_EN
    exp_pc = 6;
`else
    exp_pc = 70;
`endif
    check("t6_call_ret", int'(bus.pc), exp_pc);
    check("t6_err_sticky", int'(bus.err), exp_err);
    reset_n = 0; tick(); reset_n = 1;
    check("t6_err_clear", int'(bus.err), 0);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
